// File: rtl/synch_ram_arbiter_pkg.sv
// Shared types and constants for the two-port synch_ram arbiter.
// Pure declarations: no latency and no flow control.
package synch_ram_arb_pkg;

    localparam int ARB_AW = 16;
    localparam int ARB_DW = 8;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STROBE = 2'b01,
        DONE   = 2'b10
    } state_t;

endpackage

// File: rtl/synch_ram_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick with an optional hold for the previous owner.
// Zero latency; no backpressure (the caller decides when the pick is taken).
module rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    input  logic i_lock,
    output logic o_winner,
    output logic o_any
);

    always_comb begin
        o_any = i_req0 | i_req1;
        // A held lock only wins if its owner is still asking.
        if (i_lock && (i_last ? i_req1 : i_req0)) begin
            o_winner = i_last;
        end else if (i_req0 && i_req1) begin
            o_winner = ~i_last;
        end else begin
            o_winner = i_req1;
        end
    end

endmodule

// File: rtl/synch_ram_arbiter.sv
// Round-robin sharing of one synch_ram between two req/ack ports; optional SYNCH_RAM_ARB_LOCK_EN burst lock.
// Latency: ack 3 cycles after req sampled in IDLE; backpressure: req held until ack, max 1 access / 3 cycles.
module synch_ram_arbiter
    import synch_ram_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
) (
    input  logic          clk,
    input  logic          rst,
`ifdef SYNCH_RAM_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          gnt_id,
    output logic          ram_cs,
    output logic          ram_wen,
    output logic          ram_ren,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    state_t r_state;
    logic   r_last;
    logic   r_we;
    logic   w_winner;
    logic   w_any;
    logic   w_lock;

`ifdef SYNCH_RAM_ARB_LOCK_EN
    logic r_lock_hold;
    assign w_lock = r_lock_hold;
`else
    assign w_lock = 1'b0;
`endif

    rr_arb2 u_rr_arb2 (
        .i_req0   (req0),
        .i_req1   (req1),
        .i_last   (r_last),
        .i_lock   (w_lock),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    assign w_sel_we    = w_winner ? we1    : we0;
    assign w_sel_addr  = w_winner ? addr1  : addr0;
    assign w_sel_wdata = w_winner ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= P1;
            r_we      <= 1'b0;
            gnt_id    <= P0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            ram_cs    <= 1'b0;
            ram_wen   <= 1'b0;
            ram_ren   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
`ifdef SYNCH_RAM_ARB_LOCK_EN
            r_lock_hold <= 1'b0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
`ifdef SYNCH_RAM_ARB_LOCK_EN
                    r_lock_hold <= 1'b0;
`endif
                    if (w_any) begin
                        r_state   <= STROBE;
                        gnt_id    <= w_winner;
                        r_last    <= w_winner;
                        r_we      <= w_sel_we;
                        ram_cs    <= 1'b1;
                        ram_wen   <= w_sel_we;
                        ram_ren   <= ~w_sel_we;
                        ram_addr  <= w_sel_addr;
                        ram_wdata <= w_sel_wdata;
                    end
                end
                STROBE: begin
                    // The RAM samples its controls on this edge; drop them for DONE.
                    r_state <= DONE;
                    ram_cs  <= 1'b0;
                    ram_wen <= 1'b0;
                    ram_ren <= 1'b0;
                end
                DONE: begin
                    r_state <= IDLE;
                    if (gnt_id) begin
                        ack1 <= 1'b1;
                        if (!r_we) rdata1 <= ram_rdata;
                    end else begin
                        ack0 <= 1'b1;
                        if (!r_we) rdata0 <= ram_rdata;
                    end
`ifdef SYNCH_RAM_ARB_LOCK_EN
                    r_lock_hold <= gnt_id ? (lock1 & req1) : (lock0 & req0);
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
